// File: rtl/ss_pkg.sv
// Shared constants and FSM state encoding for the ss_rfifo burst-read buffer.
package ss_pkg;

   localparam int SS_DW        = 64;
   localparam int SS_DEPTH_DEF = 16;
   localparam int SS_BURST_DEF = 8;

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_DRAIN = 2'd1,
      S_DONE  = 2'd2
   } ss_state_e;

endpackage

// File: rtl/ss_rfifo_if.sv
// Producer/consumer/status bundle between the buffer-read engine and ss_rfifo.
interface ss_rfifo_if #(
   parameter int DEPTH = ss_pkg::SS_DEPTH_DEF
) ();
   import ss_pkg::*;

   localparam int CW = $clog2(DEPTH) + 1;

   logic [SS_DW-1:0] wr_dat_i;
   logic             wr_en_i;
   logic             ss_done;
   logic             ss_ready;
   logic [SS_DW-1:0] rd_dat_o;
   logic             rd_valid_o;
   logic             rd_ready_i;
   logic [CW-1:0]    fifo_cnt_o;
   logic             ovf_o;
   logic             done_o;
   logic [31:0]      stat_beats_o;

   modport slave (
      input  wr_dat_i, wr_en_i, ss_done, rd_ready_i,
      output ss_ready, rd_dat_o, rd_valid_o, fifo_cnt_o, ovf_o, done_o, stat_beats_o
   );

   modport master (
      output wr_dat_i, wr_en_i, ss_done, rd_ready_i,
      input  ss_ready, rd_dat_o, rd_valid_o, fifo_cnt_o, ovf_o, done_o, stat_beats_o
   );
endinterface

// File: rtl/ss_rfifo_ram.sv
// DEPTH x 64 storage: one synchronous write port, one asynchronous read port.
module ss_rfifo_ram
   import ss_pkg::*;
#(
   parameter int DEPTH = SS_DEPTH_DEF,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [SS_DW-1:0] wdat,
   input  logic [AW-1:0]    raddr,
   output logic [SS_DW-1:0] rdat
);

   logic [SS_DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdat;
   end

   assign rdat = mem[raddr];

endmodule

// File: rtl/ss_rfifo.sv
// First-word-fall-through buffer for a burst read with drain-on-done sequencing.
// Optional beat counter on stat_beats_o is enabled by defining SS_RFIFO_STAT_EN.
//
//   state   | meaning
//   S_RUN   | normal operation, pushes accepted, ss_ready tracks free space
//   S_DRAIN | pushes ignored, pops continue until empty
//   S_DONE  | one-cycle done_o pulse, pointers/ovf/stat cleared
module ss_rfifo
   import ss_pkg::*;
#(
   parameter int DEPTH = SS_DEPTH_DEF,
   parameter int BURST = SS_BURST_DEF
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_n_i,
   ss_rfifo_if.slave  bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   ss_state_e      state_q, state_d;
   logic [CW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           ss_ready_q, ready_d;
   logic           ovf_q;
   logic           full, empty, pop, push_req, push, drop;

   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign pop      = !empty && bus.rd_ready_i;
   assign push_req = bus.wr_en_i && (state_q == S_RUN);
   // A pop in the same cycle frees the slot, so a push at full still lands.
   assign push     = push_req && (!full || pop);
   assign drop     = push_req && full && !pop;

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) state_q <= S_RUN;
      else             state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ready_d = 1'b0;
      case (state_q)
         S_RUN:   if (bus.ss_done) state_d = S_DRAIN;
         S_DRAIN: if (cnt_q == '0) state_d = S_DONE;
         S_DONE:  state_d = S_RUN;
         default: state_d = S_RUN;
      endcase
      if (state_q == S_DONE) cnt_d = '0;
      else                   cnt_d = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      ready_d = (state_d == S_RUN) && ((CW'(DEPTH) - cnt_d) >= CW'(BURST));
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         ss_ready_q <= 1'b1;
         ovf_q      <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         ss_ready_q <= ready_d;
         if (state_q == S_DONE) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (drop) ovf_q    <= 1'b1;
         end
      end
   end

`ifdef SS_RFIFO_STAT_EN
   logic [31:0] stat_q;

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i)              stat_q <= '0;
      else if (state_q == S_DONE)   stat_q <= '0;
      else if (push && stat_q != '1) stat_q <= stat_q + 32'd1;
   end

   assign bus.stat_beats_o = stat_q;
`else
   assign bus.stat_beats_o = '0;
`endif

   ss_rfifo_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk   (wb_clk_i),
      .we    (push),
      .waddr (wr_ptr_q[AW-1:0]),
      .wdat  (bus.wr_dat_i),
      .raddr (rd_ptr_q[AW-1:0]),
      .rdat  (bus.rd_dat_o)
   );

   assign bus.rd_valid_o = !empty;
   assign bus.fifo_cnt_o = cnt_q;
   assign bus.ss_ready   = ss_ready_q;
   assign bus.ovf_o      = ovf_q;
   assign bus.done_o     = (state_q == S_DONE);

endmodule

// File: tb/tb_ss_rfifo.sv
// Scoreboard bench for ss_rfifo: directed scenarios followed by randomized traffic.
module tb_ss_rfifo;
   import ss_pkg::*;

   localparam int DEPTH = 16;
   localparam int BURST = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   ss_rfifo_if #(.DEPTH(DEPTH)) bus ();

   ss_rfifo #(.DEPTH(DEPTH), .BURST(BURST)) dut (
      .wb_clk_i   (clk),
      .wb_rst_n_i (rst_n),
      .bus        (bus.slave)
   );

   always #5 clk = ~clk;

   // Reference model: occupancy, mode (0 run, 1 drain, 2 done), sticky flags, data queue.
   int          m_cnt = 0;
   int          m_mode = 0;
   bit          m_ovf = 0;
   bit          m_ready = 1;
   longint      m_stat = 0;
   logic [63:0] sb_q[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, act, req);
      end
   endtask

   always @(negedge clk) begin
      logic [63:0] e;
      if (rst_n === 1'b1 && bus.rd_valid_o === 1'b1 && bus.rd_ready_i === 1'b1) begin
         checks++;
         if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL pop_data at %0t: actual=%h required=none (queue empty)", $time, bus.rd_dat_o);
         end else begin
            e = sb_q.pop_front();
            if (bus.rd_dat_o !== e) begin
               failures++;
               $display("FAIL pop_data at %0t: actual=%h required=%h", $time, bus.rd_dat_o, e);
            end
         end
      end
   end

   task automatic step(input bit rst, input bit we, input logic [63:0] d, input bit dn, input bit rr);
      bit pop, preq, acc;
      logic [31:0] exp_stat;
      rst_n = rst;
      bus.wr_en_i = we;
      bus.wr_dat_i = d;
      bus.ss_done = dn;
      bus.rd_ready_i = rr;
      if (!rst || m_mode == 2) begin
         m_cnt = 0; m_mode = 0; m_ovf = 0; m_stat = 0;
         sb_q.delete();
      end else begin
         pop  = (m_cnt > 0) && rr;
         preq = we && (m_mode == 0);
         acc  = preq && (m_cnt < DEPTH || pop);
         if (preq && !acc) m_ovf = 1;
         if (acc) begin
            sb_q.push_back(d);
            if (m_stat < 64'h0000_0000_FFFF_FFFF) m_stat++;
         end
         if (m_mode == 0 && dn)          m_mode = 1;
         else if (m_mode == 1 && m_cnt == 0) m_mode = 2;
         m_cnt = m_cnt + int'(acc) - int'(pop);
      end
      m_ready = (m_mode == 0) && (DEPTH - m_cnt >= BURST);
`ifdef SS_RFIFO_STAT_EN
      exp_stat = m_stat[31:0];
`else
      exp_stat = 32'd0;
`endif
      @(posedge clk); #1;
      chk("fifo_cnt", 64'(bus.fifo_cnt_o), 64'(m_cnt));
      chk("rd_valid", 64'(bus.rd_valid_o), 64'(m_cnt != 0));
      chk("ss_ready", 64'(bus.ss_ready), 64'(m_ready));
      chk("ovf", 64'(bus.ovf_o), 64'(m_ovf));
      chk("done", 64'(bus.done_o), 64'(m_mode == 2));
      chk("stat_beats", 64'(bus.stat_beats_o), 64'(exp_stat));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog at %0t: actual=timeout required=finish", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int done_seen;
      bus.wr_en_i = 0; bus.wr_dat_i = '0; bus.ss_done = 0; bus.rd_ready_i = 0;
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);

      // Eight beats, no consumer: still one burst of room; the ninth takes it away.
      for (int i = 1; i <= 8; i++) step(1, 1, 64'(i), 0, 0);
      chk("s22_cnt8", 64'(bus.fifo_cnt_o), 64'd8);
      chk("s22_ready8", 64'(bus.ss_ready), 64'd1);
      step(1, 1, 64'd9, 0, 0);
      chk("s22_ready9", 64'(bus.ss_ready), 64'd0);

      // Fill to full, then an extra beat is dropped and flagged.
      for (int i = 10; i <= 16; i++) step(1, 1, 64'(i), 0, 0);
      step(1, 1, 64'd17, 0, 0);
      chk("s23_ovf", 64'(bus.ovf_o), 64'd1);
      chk("s23_cnt", 64'(bus.fifo_cnt_o), 64'd16);
      chk("s23_head", bus.rd_dat_o, 64'd1);

      // Full with simultaneous push and pop.
      step(0, 0, 0, 0, 0);
      for (int i = 1; i <= 16; i++) step(1, 1, 64'(i), 0, 0);
      step(1, 1, 64'hAA, 0, 1);
      chk("s24_cnt", 64'(bus.fifo_cnt_o), 64'd16);
      chk("s24_ovf", 64'(bus.ovf_o), 64'd0);
      for (int i = 0; i < 15; i++) step(1, 0, 0, 0, 1);
      chk("s24_head", bus.rd_dat_o, 64'hAA);
      step(1, 0, 0, 0, 1);

      // Drain sequence with five entries queued.
      step(0, 0, 0, 0, 0);
      for (int i = 1; i <= 5; i++) step(1, 1, 64'(100 + i), 0, 0);
      step(1, 0, 0, 1, 0);
      chk("s25_ready_drain", 64'(bus.ss_ready), 64'd0);
      done_seen = 0;
      for (int i = 0; i < 20; i++) begin
         step(1, 0, 0, 0, 1);
         if (bus.done_o === 1'b1) done_seen++;
      end
      chk("s25_done_count", 64'(done_seen), 64'd1);
      chk("s25_ready_after", 64'(bus.ss_ready), 64'd1);

      // Empty FIFO on ss_done still passes through drain and done.
      step(1, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0);
      chk("s14_done", 64'(bus.done_o), 64'd1);
      step(1, 0, 0, 0, 0);

      // Reset in the middle of a drain.
      for (int i = 1; i <= 10; i++) step(1, 1, 64'(200 + i), 0, 0);
      step(1, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("s26_valid", 64'(bus.rd_valid_o), 64'd0);
      chk("s26_ready", 64'(bus.ss_ready), 64'd1);
      step(1, 1, 64'h5A5A, 0, 0);
      step(1, 0, 0, 0, 1);

      // 20 pushes, one pop at full, three dropped.
      step(0, 0, 0, 0, 0);
      for (int i = 1; i <= 16; i++) step(1, 1, 64'(300 + i), 0, 0);
      step(1, 1, 64'd317, 0, 1);
      for (int i = 18; i <= 20; i++) step(1, 1, 64'(300 + i), 0, 0);
`ifdef SS_RFIFO_STAT_EN
      chk("s27_stat", 64'(bus.stat_beats_o), 64'd17);
`else
      chk("s27_stat", 64'(bus.stat_beats_o), 64'd0);
`endif

      // Randomized traffic with occasional done pulses and resets.
      for (int i = 0; i < 3000; i++) begin
         bit r, w, dn, rr;
         r  = ($urandom_range(0, 299) != 0);
         w  = ($urandom_range(0, 9) < 7);
         dn = ($urandom_range(0, 59) == 0);
         rr = r && ($urandom_range(0, 1) == 1);
         step(r, w, {$urandom, $urandom}, dn, rr);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
